// File: rtl/keypad_lock_pkg.sv
// ============================================================================
// Module  : keypad_lock_pkg
// Brief   : Shared state encodings and sizing helper for the keypad lock.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_lock_pkg;

    typedef logic [1:0] lock_state_t;

    localparam lock_state_t ST_LOCKED   = 2'd0;
    localparam lock_state_t ST_UNLOCKED = 2'd1;
    localparam lock_state_t ST_CHANGE   = 2'd2;
    localparam lock_state_t ST_LOCKOUT  = 2'd3;

    // Width needed to hold the values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_entry_buf.sv
// ============================================================================
// Module  : keypad_entry_buf
// Brief   : Digit shift buffer with saturating count; clear wins over a digit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_entry_buf
    import keypad_lock_pkg::*;
#(
    parameter int DIGIT_W    = 4,
    parameter int NUM_DIGITS = 4
)(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_clear,
    input  logic                          i_digit_valid,
    input  logic [DIGIT_W-1:0]            i_digit,
    output logic [DIGIT_W*NUM_DIGITS-1:0] o_buf,
    output logic                          o_full
);

    localparam int BUF_W = DIGIT_W * NUM_DIGITS;
    localparam int CNT_W = cnt_width(NUM_DIGITS);

    logic [BUF_W-1:0] r_buf;
    logic [CNT_W-1:0] r_count;
    logic             w_full;

    assign w_full = (r_count == CNT_W'(NUM_DIGITS));

    // New digits enter at the LS end, so the first digit typed ends up MS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf   <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_buf   <= '0;
            r_count <= '0;
        end else if (i_digit_valid && !w_full) begin
            r_buf   <= (r_buf << DIGIT_W) | BUF_W'(i_digit);
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_buf  = r_buf;
    assign o_full = w_full;

endmodule

`default_nettype wire

// File: rtl/keypad_lock_ctrl.sv
// ============================================================================
// Module  : keypad_lock_ctrl
// Brief   : Multi-digit keypad lock FSM with lockout, auto-relock, code change.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_lock_ctrl
    import keypad_lock_pkg::*;
#(
    parameter int DIGIT_W        = 4,
    parameter int NUM_DIGITS     = 4,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int RELOCK_CYCLES  = 500,
    parameter logic [DIGIT_W*NUM_DIGITS-1:0] DEFAULT_CODE = '1
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               digit_valid,
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic               enter,
    input  logic               clear,
    input  logic               change_req,
    input  logic               lock_req,
    input  logic               door_closed,
    output logic               door_locked,
    output logic               correct_pulse,
    output logic               wrong_pulse,
    output logic               change_done,
    output logic               lockout,
    output logic [1:0]         state_o
);

    localparam int CODE_W = DIGIT_W * NUM_DIGITS;
    localparam int FAIL_W = cnt_width(MAX_TRIES);
    localparam int LOCK_W = cnt_width(LOCKOUT_CYCLES);
    localparam int REL_W  = cnt_width(RELOCK_CYCLES);

    lock_state_t       r_state;
    logic [CODE_W-1:0] r_code;
    logic [FAIL_W-1:0] r_fail;
    logic [LOCK_W-1:0] r_lock_tmr;
    logic [REL_W-1:0]  r_relock;
    logic              r_door_locked;
    logic              r_correct;
    logic              r_wrong;
    logic              r_change_done;
    logic              r_lockout;

    lock_state_t       w_next_state;
    logic [FAIL_W-1:0] w_fail_next;
    logic [CODE_W-1:0] w_buf;
    logic              w_buf_full;
    logic              w_buf_clr;
    logic              w_enter;
    logic              w_match;
    logic              w_relock_exp;
    logic              w_lock_exp;
    logic              w_correct;
    logic              w_wrong;
    logic              w_change_done;
    logic              w_code_we;

    assign w_enter      = enter & ~clear;
    assign w_match      = w_buf_full && (w_buf == r_code);
    assign w_relock_exp = door_closed && (r_relock == REL_W'(RELOCK_CYCLES - 1));
    assign w_lock_exp   = (r_lock_tmr == LOCK_W'(LOCKOUT_CYCLES - 1));

    // Buffer is flushed by any submission, any state change, and throughout lockout.
    assign w_buf_clr = clear | enter | (w_next_state != r_state) | (r_state == ST_LOCKOUT);

    keypad_entry_buf #(
        .DIGIT_W    (DIGIT_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_entry_buf (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clear       (w_buf_clr),
        .i_digit_valid (digit_valid),
        .i_digit       (digit_in),
        .o_buf         (w_buf),
        .o_full        (w_buf_full)
    );

    always_comb begin
        w_next_state  = r_state;
        w_fail_next   = r_fail;
        w_correct     = 1'b0;
        w_wrong       = 1'b0;
        w_change_done = 1'b0;
        w_code_we     = 1'b0;
        case (r_state)
            ST_LOCKED: begin
                if (w_enter) begin
                    if (w_match) begin
                        w_next_state = ST_UNLOCKED;
                        w_correct    = 1'b1;
                        w_fail_next  = '0;
                    end else begin
                        w_wrong = 1'b1;
                        if (r_fail == FAIL_W'(MAX_TRIES - 1)) begin
                            w_next_state = ST_LOCKOUT;
                            w_fail_next  = '0;
                        end else begin
                            w_fail_next = r_fail + FAIL_W'(1);
                        end
                    end
                end
            end
            ST_UNLOCKED: begin
                w_wrong = w_enter && !w_match;
                if (lock_req && door_closed) begin
                    w_next_state = ST_LOCKED;
                end else if (w_relock_exp) begin
                    w_next_state = ST_LOCKED;
                end else if (change_req) begin
                    w_next_state = ST_CHANGE;
                end
            end
            ST_CHANGE: begin
                if (change_req) begin
                    w_next_state = ST_UNLOCKED;
                end else if (w_enter) begin
                    if (w_buf_full) begin
                        w_code_we     = 1'b1;
                        w_change_done = 1'b1;
                        w_next_state  = ST_UNLOCKED;
                    end else begin
                        w_wrong = 1'b1;
                    end
                end
            end
            default: begin
                if (w_lock_exp) begin
                    w_next_state = ST_LOCKED;
                end
            end
        endcase
    end

    // Timers count only while staying in their state, so they never run past terminal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_LOCKED;
            r_code        <= DEFAULT_CODE;
            r_fail        <= '0;
            r_lock_tmr    <= '0;
            r_relock      <= '0;
            r_door_locked <= 1'b1;
            r_correct     <= 1'b0;
            r_wrong       <= 1'b0;
            r_change_done <= 1'b0;
            r_lockout     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_fail  <= w_fail_next;
            if (w_code_we) begin
                r_code <= w_buf;
            end
            r_lock_tmr <= (r_state == ST_LOCKOUT && w_next_state == ST_LOCKOUT)
                          ? r_lock_tmr + LOCK_W'(1) : '0;
            r_relock   <= (r_state == ST_UNLOCKED && w_next_state == ST_UNLOCKED && door_closed)
                          ? r_relock + REL_W'(1) : '0;
            r_door_locked <= (w_next_state == ST_LOCKED) || (w_next_state == ST_LOCKOUT);
            r_lockout     <= (w_next_state == ST_LOCKOUT);
            r_correct     <= w_correct;
            r_wrong       <= w_wrong;
            r_change_done <= w_change_done;
        end
    end

    assign door_locked   = r_door_locked;
    assign correct_pulse = r_correct;
    assign wrong_pulse   = r_wrong;
    assign change_done   = r_change_done;
    assign lockout       = r_lockout;
    assign state_o       = r_state;

endmodule

`default_nettype wire

// File: tb/tb_keypad_lock_ctrl.sv
// ============================================================================
// Module  : tb_keypad_lock_ctrl
// Brief   : Directed self-checking bench for keypad_lock_ctrl (default params).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       digit_valid = 1'b0;
    logic [3:0] digit_in = 4'h0;
    logic       enter = 1'b0;
    logic       clear = 1'b0;
    logic       change_req = 1'b0;
    logic       lock_req = 1'b0;
    logic       door_closed = 1'b1;
    logic       door_locked;
    logic       correct_pulse;
    logic       wrong_pulse;
    logic       change_done;
    logic       lockout;
    logic [1:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    keypad_lock_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .digit_valid   (digit_valid),
        .digit_in      (digit_in),
        .enter         (enter),
        .clear         (clear),
        .change_req    (change_req),
        .lock_req      (lock_req),
        .door_closed   (door_closed),
        .door_locked   (door_locked),
        .correct_pulse (correct_pulse),
        .wrong_pulse   (wrong_pulse),
        .change_done   (change_done),
        .lockout       (lockout),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    // Called at a falling edge; applies inputs across one rising edge and returns
    // at the next falling edge, where that edge's registered outputs are visible.
    task automatic drive(input logic dv, input logic [3:0] d, input logic en,
                         input logic clr, input logic chg, input logic lk);
        digit_valid = dv; digit_in = d; enter = en;
        clear = clr; change_req = chg; lock_req = lk;
        @(negedge clk);
        digit_valid = 1'b0; enter = 1'b0; clear = 1'b0;
        change_req = 1'b0; lock_req = 1'b0;
    endtask

    task automatic key(input logic [3:0] d);
        drive(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_enter();
        drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic enter_code(input logic [15:0] c);
        for (int i = 0; i < 4; i++) key(c[15-4*i -: 4]);
        press_enter();
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({door_locked, state_o, lockout, correct_pulse, wrong_pulse, change_done} !== 7'b1_00_0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 1000000",
                     {door_locked, state_o, lockout, correct_pulse, wrong_pulse, change_done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        n_checks++;
        if (state_o !== 2'd0 || door_locked !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_idle: state %0d locked %b required 0 1", state_o, door_locked);
        end
    endtask

    task automatic test_default_unlock();
        enter_code(16'hFFFF);
        n_checks++;
        if (correct_pulse !== 1'b1 || wrong_pulse !== 1'b0 || door_locked !== 1'b0 || state_o !== 2'd1) begin
            n_fail++;
            $display("FAIL default_unlock: correct %b wrong %b locked %b state %0d required 1 0 0 1",
                     correct_pulse, wrong_pulse, door_locked, state_o);
        end
        idle(1);
        n_checks++;
        if (correct_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL correct_width: got %b required 0", correct_pulse);
        end
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (state_o !== 2'd0 || door_locked !== 1'b1) begin
            n_fail++;
            $display("FAIL manual_lock: state %0d locked %b required 0 1", state_o, door_locked);
        end
    endtask

    task automatic test_wrong_and_lockout();
        int n;
        int j;
        logic bad;
        key(4'h1); key(4'h2); key(4'h3); press_enter();
        n_checks++;
        if (wrong_pulse !== 1'b1 || state_o !== 2'd0) begin
            n_fail++;
            $display("FAIL short_entry: wrong %b state %0d required 1 0", wrong_pulse, state_o);
        end
        enter_code(16'hFFFF);
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int t = 0; t < 2; t++) begin
            enter_code(16'h1234);
            n_checks++;
            if (wrong_pulse !== 1'b1 || lockout !== 1'b0 || state_o !== 2'd0) begin
                n_fail++;
                $display("FAIL wrong_try%0d: wrong %b lockout %b state %0d required 1 0 0",
                         t, wrong_pulse, lockout, state_o);
            end
        end
        enter_code(16'h1234);
        n_checks++;
        if (lockout !== 1'b1 || state_o !== 2'd3 || door_locked !== 1'b1) begin
            n_fail++;
            $display("FAIL lockout_entry: lockout %b state %0d locked %b required 1 3 1",
                     lockout, state_o, door_locked);
        end
        n = 1; j = 0; bad = 1'b0;
        while (lockout === 1'b1 && j < 2000) begin
            j++;
            case (j)
                1: key(4'h1);
                2: key(4'h2);
                3: key(4'h3);
                4: key(4'h4);
                5: press_enter();
                6: drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
                default: idle(1);
            endcase
            if (correct_pulse | wrong_pulse | change_done) bad = 1'b1;
            if (lockout === 1'b1) n++;
        end
        n_checks++;
        if (n !== 1000) begin
            n_fail++;
            $display("FAIL lockout_length: got %0d cycles required 1000", n);
        end
        n_checks++;
        if (bad !== 1'b0 || state_o !== 2'd0 || door_locked !== 1'b1) begin
            n_fail++;
            $display("FAIL lockout_exit: pulses_seen %b state %0d locked %b required 0 0 1",
                     bad, state_o, door_locked);
        end
        enter_code(16'hFFFF);
        n_checks++;
        if (correct_pulse !== 1'b1 || state_o !== 2'd1) begin
            n_fail++;
            $display("FAIL buffer_empty_after_lockout: correct %b state %0d required 1 1",
                     correct_pulse, state_o);
        end
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Unlocks with the default code, opens the door on cycles lo..hi, counts unlocked cycles.
    task automatic measure_relock(input int lo, input int hi, input int expected, input string tag);
        int n;
        logic done;
        enter_code(16'hFFFF);
        n = 1; done = 1'b0;
        for (int j = 1; j <= 2000 && !done; j++) begin
            door_closed = (j >= lo && j <= hi) ? 1'b0 : 1'b1;
            idle(1);
            if (door_locked === 1'b1) done = 1'b1;
            else n++;
        end
        door_closed = 1'b1;
        n_checks++;
        if (n !== expected || state_o !== 2'd0) begin
            n_fail++;
            $display("FAIL %s: unlocked %0d cycles state %0d required %0d cycles state 0",
                     tag, n, state_o, expected);
        end
    endtask

    task automatic test_change_code();
        enter_code(16'hFFFF);
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (state_o !== 2'd2 || door_locked !== 1'b0) begin
            n_fail++;
            $display("FAIL enter_change: state %0d locked %b required 2 0", state_o, door_locked);
        end
        key(4'h1); key(4'h2); press_enter();
        n_checks++;
        if (wrong_pulse !== 1'b1 || state_o !== 2'd2 || change_done !== 1'b0) begin
            n_fail++;
            $display("FAIL change_short: wrong %b state %0d done %b required 1 2 0",
                     wrong_pulse, state_o, change_done);
        end
        enter_code(16'h5A03);
        n_checks++;
        if (change_done !== 1'b1 || state_o !== 2'd1) begin
            n_fail++;
            $display("FAIL change_commit: done %b state %0d required 1 1", change_done, state_o);
        end
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        enter_code(16'hFFFF);
        n_checks++;
        if (wrong_pulse !== 1'b1 || state_o !== 2'd0) begin
            n_fail++;
            $display("FAIL old_code_rejected: wrong %b state %0d required 1 0", wrong_pulse, state_o);
        end
        enter_code(16'h5A03);
        n_checks++;
        if (correct_pulse !== 1'b1 || state_o !== 2'd1) begin
            n_fail++;
            $display("FAIL new_code_accepted: correct %b state %0d required 1 1", correct_pulse, state_o);
        end
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_clear_priority_and_reset();
        key(4'h7); key(4'h7);
        drive(1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0);
        key(4'h5); key(4'hA); key(4'h0); key(4'h3); key(4'h9); key(4'h9);
        press_enter();
        n_checks++;
        if (correct_pulse !== 1'b1 || state_o !== 2'd1) begin
            n_fail++;
            $display("FAIL clear_priority: correct %b state %0d required 1 1", correct_pulse, state_o);
        end
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        key(4'h1); key(4'h2); key(4'h3); key(4'h4);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (state_o !== 2'd0 || door_locked !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset_mid_change: state %0d locked %b required 0 1", state_o, door_locked);
        end
        @(negedge clk);
        rst_n = 1'b1;
        enter_code(16'h5A03);
        n_checks++;
        if (wrong_pulse !== 1'b1 || state_o !== 2'd0) begin
            n_fail++;
            $display("FAIL changed_code_lost: wrong %b state %0d required 1 0", wrong_pulse, state_o);
        end
        enter_code(16'hFFFF);
        n_checks++;
        if (correct_pulse !== 1'b1 || state_o !== 2'd1) begin
            n_fail++;
            $display("FAIL default_restored: correct %b state %0d required 1 1", correct_pulse, state_o);
        end
    endtask

    task automatic test_lock_precedence();
        door_closed = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        door_closed = 1'b1;
        n_checks++;
        if (state_o !== 2'd1 || door_locked !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_door_open: state %0d locked %b required 1 0", state_o, door_locked);
        end
        idle(499);
        n_checks++;
        if (state_o !== 2'd1) begin
            n_fail++;
            $display("FAIL timer_restart: state %0d required 1", state_o);
        end
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (state_o !== 2'd0 || door_locked !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_beats_change: state %0d locked %b required 0 1", state_o, door_locked);
        end
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (state_o !== 2'd0) begin
            n_fail++;
            $display("FAIL change_ignored_locked: state %0d required 0", state_o);
        end
    endtask

    initial begin
        test_reset();
        test_default_unlock();
        test_wrong_and_lockout();
        measure_relock(0, -1, 500, "relock_closed");
        measure_relock(300, 309, 809, "relock_restart");
        test_change_code();
        test_clear_priority_and_reset();
        test_lock_precedence();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/keypad_lock_ctrl.md
Name: keypad_lock_ctrl

Overview:
- Parametrised successor to the single-nibble door lock.
- Accepts a multi-digit code one digit per strobe and compares it on an explicit enter.
- Adds a consecutive-failure lockout, timed auto-relock and guarded code change (only from the unlocked state).
- Sits between the keypad scanner and the door actuator/status LEDs.

Parameters:
DIGIT_W, 4, width of one keypad digit
NUM_DIGITS, 4, digits per code
MAX_TRIES, 3, consecutive wrong entries that trigger lockout (>=1)
LOCKOUT_CYCLES, 1000, clock cycles spent in lockout (>=1)
RELOCK_CYCLES, 500, cycles the door must stay closed while unlocked before automatic relock (>=1)
DEFAULT_CODE, all ones (DIGIT_W*NUM_DIGITS bits), code loaded at reset; digit 0 occupies the MS digit

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
digit_valid  in  1  one-cycle strobe, digit_in valid
digit_in  in  DIGIT_W  keypad digit
enter  in  1  one-cycle strobe, submit buffered digits
clear  in  1  one-cycle strobe, discard buffered digits
change_req  in  1  one-cycle strobe, enter/abort code-change mode
lock_req  in  1  one-cycle strobe, manual lock
door_closed  in  1  sensor, 1 = door physically closed
door_locked  out  1  actuator, 1 = bolt thrown
correct_pulse  out  1  one-cycle, accepted code
wrong_pulse  out  1  one-cycle, rejected entry
change_done  out  1  one-cycle, new code committed
lockout  out  1  high throughout LOCKOUT
state_o  out  2  current state encoding, debug

Behaviour:
- Reset (rst_n low, async):
  - state=LOCKED, code=DEFAULT_CODE, buffer and count cleared, fail count 0, timers 0.
  - door_locked=1; every pulse output, lockout and state_o = 0.
- States: LOCKED=0, UNLOCKED=1, CHANGE=2, LOCKOUT=3. All outputs are registered.
- Entry buffer:
  - digit_valid shifts digit_in in at the LS digit; count increments and saturates at NUM_DIGITS.
  - Digits received while full are dropped.
  - Buffer and count clear on clear, on every enter, and on every state change.
- Same-cycle priority: clear > enter > digit_valid. A digit arriving in the enter or clear cycle is discarded.
- Output timing: enter sampled at edge k → pulse outputs high for exactly the cycle after edge k. door_locked and state_o update on the same edge k.
- LOCKED:
  - enter with count==NUM_DIGITS and buffer==code → UNLOCKED, door_locked=0, correct_pulse, fail count 0.
  - Any other enter (including a short buffer) → wrong_pulse, fail count +1.
  - When the fail count reaches MAX_TRIES → LOCKOUT instead, lockout=1, fail count 0.
  - change_req and lock_req are ignored.
- UNLOCKED:
  - Relock timer counts while door_closed=1 and resets to 0 while door_closed=0.
  - Timer reaching RELOCK_CYCLES-1 → LOCKED, door_locked=1.
  - lock_req with door_closed=1 → LOCKED next edge; lock_req with door open is ignored.
  - change_req → CHANGE.
  - enter → wrong_pulse only if the buffer mismatches; no state change either way.
- CHANGE:
  - door_locked stays 0; relock timer held at 0.
  - enter with count==NUM_DIGITS → code<=buffer, change_done, → UNLOCKED.
  - enter with a short buffer → wrong_pulse, stay in CHANGE.
  - change_req → abort to UNLOCKED, code unchanged.
- LOCKOUT:
  - All keypad inputs are ignored and the buffer is held empty.
  - After LOCKOUT_CYCLES cycles → LOCKED, lockout=0.
- Precedence in UNLOCKED, same cycle: lock_req > timer expiry > change_req.
- Arithmetic: counter widths = $clog2(max+1); no wrap — every counter saturates or is cleared by its state exit.
- Reset mid-entry, mid-change or mid-lockout: immediate return to reset values; any partially entered new code is lost.

Decomposition:
- Shared package keypad_lock_pkg: state enum (2-bit), state encodings, helper function for counter width.
- One sub-module, keypad_entry_buf: the shift buffer, saturating count and clear/priority logic. Outputs buffer and a full flag.
- The FSM, timers and compare live in the top.

Test Plan:
- Reset, then digits F,F,F,F + enter → correct_pulse 1 cycle after enter, door_locked 0, state_o=1.
- Digits 1,2,3 + enter → wrong_pulse, state stays LOCKED. Three full wrong codes (1,2,3,4) → lockout=1 for exactly 1000 cycles, digits ignored meanwhile, then LOCKED.
- Unlock with door_closed=1 held → door_locked=1 after 500 cycles. Repeat with door_closed dropping to 0 at cycle 300 → timer restarts from 0.
- Unlock, change_req, digits 5,A,0,3 + enter → change_done. Lock, then F,F,F,F fails and 5,A,0,3 succeeds.
- Send digit_valid and clear in the same cycle, then 6 digits + enter → only the first 4 digits after the clear are compared. Also deassert rst_n mid-CHANGE → code reverts to FFFF.
- In UNLOCKED, lock_req with door_closed=0 → no change. Then lock_req, timer expiry and change_req together with door_closed=1 → LOCKED.
